// File: rtl/dct_pkg.sv
// Shared FSM encoding and the 8x8 DCT-II cosine table used by full_dct_stream.
// The table is derived from Q24 constants, rounded half away from zero to COEF_FRAC (<= 24) bits.
package dct_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } dct_state_t;

  // c(k)*cos(m*pi/16) in Q24 for k>0, m = 0..8; DC row uses sqrt(1/8)
  localparam int COS_Q24 [9] = '{8388608, 8227423, 7750063, 6974873, 5931642,
                                 4660461, 3210181, 1636536, 0};
  localparam int DC_Q24 = 5931642;

  function automatic int dct_coef(input int k, input int n, input int frac);
    int m;
    int mag;
    int sh;
    bit neg;
    m   = ((2 * n + 1) * k) & 31;
    neg = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    mag = (k == 0) ? DC_Q24 : COS_Q24[m];
    sh  = 24 - frac;
    if (sh > 0) mag = (mag + (1 << (sh - 1))) >>> sh;
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/dct_round_sat.sv
// Scales a Q(COEF_FRAC) accumulator to an integer coefficient, then saturates to OUT_W.
// Purely combinational; rounding is half away from zero or truncation toward zero.
module dct_round_sat #(
  parameter int IN_W      = 25,
  parameter int OUT_W     = 12,
  parameter int COEF_FRAC = 12,
  parameter int ROUND_EN  = 1
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] q,
  output logic                    sat
);

  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] QMAX = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] QMIN = -QMAX - EW'(1);

  function automatic logic signed [EW-1:0] scale(input logic signed [IN_W-1:0] a);
    logic signed [EW-1:0] ax;
    logic signed [EW-1:0] bias;
    ax = {a[IN_W-1], a};
    if (ROUND_EN != 0) bias = EW'(1) <<< (COEF_FRAC - 1);
    else               bias = '0;
    // negative values shift toward -inf, so bias them back toward zero
    if (a[IN_W-1])
      bias = (ROUND_EN != 0) ? bias - EW'(1) : (EW'(1) <<< COEF_FRAC) - EW'(1);
    return (ax + bias) >>> COEF_FRAC;
  endfunction

  function automatic logic [OUT_W:0] saturate(input logic signed [EW-1:0] v);
    if (v > QMAX)      return {1'b1, QMAX[OUT_W-1:0]};
    else if (v < QMIN) return {1'b1, QMIN[OUT_W-1:0]};
    else               return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic signed [EW-1:0] scaled;

  always_comb begin
    scaled   = scale(acc);
    {sat, q} = saturate(scaled);
  end

endmodule

// File: rtl/full_dct_stream.sv
// Streaming 8-point DCT-II: buffers eight samples, computes each coefficient with a
// single shared MAC (8 cycles per k), and emits coefficients over a valid/ready port.
module full_dct_stream
  import dct_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 12,
  parameter int COEF_FRAC = 12,
  parameter int ROUND_EN  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [IN_W-1:0]  s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic [2:0]              m_index,
  output logic                    m_last,
  output logic                    m_sat,
  output logic                    busy
);

  localparam int COEF_W = COEF_FRAC + 2;
  localparam int PROD_W = IN_W + COEF_W;
  localparam int ACC_W  = IN_W + COEF_FRAC + 5;

  dct_state_t state, state_nx;
  logic [2:0] n, k, j;
  logic signed [IN_W-1:0]   xbuf [8];
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coef_rom [64];
  logic signed [IN_W-1:0]   x_sel;
  logic signed [COEF_W-1:0] c_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  rs_q;
  logic                     rs_sat;

  for (genvar gi = 0; gi < 64; gi++) begin : g_rom
    assign coef_rom[gi] = COEF_W'(dct_coef(gi >> 3, gi & 7, COEF_FRAC));
  end

  assign x_sel = xbuf[j];
  assign c_sel = coef_rom[{k, j}];
  assign prod  = $signed({{COEF_W{x_sel[IN_W-1]}}, x_sel}) *
                 $signed({{IN_W{c_sel[COEF_W-1]}}, c_sel});

  assign s_ready = rst_n && en && (state == FILL);
  assign busy    = (state != FILL);

  dct_round_sat #(
    .IN_W     (ACC_W),
    .OUT_W    (OUT_W),
    .COEF_FRAC(COEF_FRAC),
    .ROUND_EN (ROUND_EN)
  ) u_round_sat (
    .acc(acc),
    .q  (rs_q),
    .sat(rs_sat)
  );

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (s_valid && s_ready && (n == 3'd7)) state_nx = COMPUTE;
      COMPUTE: if (j == 3'd7) state_nx = OUTPUT;
      OUTPUT:  if (m_valid && m_ready) state_nx = (k == 3'd7) ? FILL : COMPUTE;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      n       <= '0;
      k       <= '0;
      j       <= '0;
      acc     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
      m_sat   <= 1'b0;
      for (int i = 0; i < 8; i++) xbuf[i] <= '0;
    end else if (en) begin
      state <= state_nx;
      case (state)
        FILL: begin
          if (s_valid && s_ready) begin
            xbuf[n] <= s_data;
            n       <= n + 3'd1;
            if (n == 3'd7) begin
              k   <= '0;
              j   <= '0;
              acc <= '0;
            end
          end
        end
        // --- MAC stage: one product per cycle, j wraps back to 0 after 7
        COMPUTE: begin
          acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
          j   <= j + 3'd1;
        end
        // --- output stage: register the scaled result, then wait for the handshake
        OUTPUT: begin
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_data  <= rs_q;
            m_index <= k;
            m_last  <= (k == 3'd7);
            m_sat   <= rs_sat;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            acc     <= '0;
            j       <= '0;
            if (k == 3'd7) begin
              k <= '0;
              n <= '0;
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_full_dct_stream.sv
// Bench for full_dct_stream: three configurations share one stimulus stream and are
// checked each cycle against a real-valued DCT model plus hand-computed literals.
module tb_full_dct_stream;

  logic clk = 1'b0;
  logic rst_n, en, s_valid, m_ready;
  logic signed [7:0] s_data;
  logic s_ready0, s_ready1, s_ready2;
  logic m_valid0, m_valid1, m_valid2;
  logic signed [11:0] m_data0, m_data1;
  logic signed [7:0]  m_data2;
  logic [2:0] m_index0, m_index1, m_index2;
  logic m_last0, m_last1, m_last2, m_sat0, m_sat1, m_sat2, busy0, busy1, busy2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  full_dct_stream dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_index(m_index0),
    .m_last(m_last0), .m_sat(m_sat0), .busy(busy0));

  full_dct_stream #(.ROUND_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_index(m_index1),
    .m_last(m_last1), .m_sat(m_sat1), .busy(busy1));

  full_dct_stream #(.OUT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_index(m_index2),
    .m_last(m_last2), .m_sat(m_sat2), .busy(busy2));

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint d;
    int     idx;
    bit     last;
    bit     sat;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int fr[$];
  longint rec0[8], rec1[8], rec2[8];
  bit rsat0[8], rsat2[8], rlast0[8];
  int last_lat[8];
  int cyc = 0;
  int last_fire = -1;
  int stall = 0;
  bit prev_v = 1'b0;

  function automatic longint coef(input int k, input int n);
    real c, v;
    c = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
    v = c * $cos((2.0 * n + 1.0) * k * 3.14159265358979323846 / 16.0) * 4096.0;
    return (v >= 0.0) ? longint'($floor(v + 0.5)) : -longint'($floor(-v + 0.5));
  endfunction

  function automatic longint model_q(input longint a, input int rnd, input int outw,
                                     output bit sat);
    longint mag, q, mx;
    mag = (a < 0) ? -a : a;
    q   = (rnd != 0) ? (mag + 2048) / 4096 : mag / 4096;
    if (a < 0) q = -q;
    mx  = (64'sd1 <<< (outw - 1)) - 1;
    sat = 1'b0;
    if (q > mx) begin
      q = mx; sat = 1'b1;
    end else if (q < -mx - 1) begin
      q = -mx - 1; sat = 1'b1;
    end
    return q;
  endfunction

  task automatic push_frame();
    exp_t e;
    bit sb;
    longint a;
    for (int kk = 0; kk < 8; kk++) begin
      a = 0;
      for (int nn = 0; nn < 8; nn++) a += longint'(fr[nn]) * coef(kk, nn);
      e.idx  = kk;
      e.last = (kk == 7);
      e.d = model_q(a, 1, 12, sb); e.sat = sb; q0.push_back(e);
      e.d = model_q(a, 0, 12, sb); e.sat = sb; q1.push_back(e);
      e.d = model_q(a, 1, 8, sb);  e.sat = sb; q2.push_back(e);
    end
  endtask

  task automatic cmp_out(input string nm, input exp_t e, input longint d, input int idx,
                         input bit last, input bit sat);
    chk({nm, "_data"}, d, e.d);
    chk({nm, "_index"}, idx, e.idx);
    chk({nm, "_last"}, last, e.last);
    chk({nm, "_sat"}, sat, e.sat);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      fr.delete(); q0.delete(); q1.delete(); q2.delete();
      last_fire = -1;
      stall     = 0;
      prev_v    = 1'b0;
    end else begin
      if (m_valid0) begin
        if (q0.size() == 0) chk("unexpected_valid0", 1, 0);
        else cmp_out("z_rnd", q0[0], m_data0, m_index0, m_last0, m_sat0);
      end
      if (m_valid1) begin
        if (q1.size() == 0) chk("unexpected_valid1", 1, 0);
        else cmp_out("z_trunc", q1[0], m_data1, m_index1, m_last1, m_sat1);
      end
      if (m_valid2) begin
        if (q2.size() == 0) chk("unexpected_valid2", 1, 0);
        else cmp_out("z_w8", q2[0], m_data2, m_index2, m_last2, m_sat2);
      end
      if (m_valid0 && !prev_v && last_fire >= 0) begin
        chk("latency", cyc - last_fire - 1, 9 + stall);
        last_lat[m_index0] = cyc - last_fire - 1;
      end
      if (en && m_valid0 && m_ready && q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
        rec0[m_index0] = m_data0; rsat0[m_index0] = m_sat0; rlast0[m_index0] = m_last0;
        rec1[m_index1] = m_data1;
        rec2[m_index2] = m_data2; rsat2[m_index2] = m_sat2;
        void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
        last_fire = cyc;
        stall     = 0;
      end
      if (s_valid && s_ready0) begin
        fr.push_back(int'(s_data));
        last_fire = cyc;
        stall     = 0;
        if (fr.size() == 8) begin
          push_frame();
          fr.delete();
        end
      end
      if (!en) stall++;
      prev_v = m_valid0;
    end
  end

  // ---------------- stimulus helpers ----------------
  int frm[8];

  task automatic send_sample(input int v);
    int t;
    t = 0;
    s_data  = 8'(v);
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("s_ready_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 8; i++) send_sample(frm[i]);
  endtask

  task automatic wait_idx(input int idx);
    int t;
    t = 0;
    @(negedge clk);
    while (!(m_valid0 && m_index0 == 3'(idx)) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("wait_index_timeout", idx, -1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!(m_valid0 && m_ready && en && m_last0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("frame_done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_s_ready", s_ready0, 0);
    chk("rst_m_valid", m_valid0, 0);
    chk("rst_m_data", m_data0, 0);
    chk("rst_m_index", m_index0, 0);
    chk("rst_m_last", m_last0, 0);
    chk("rst_m_sat", m_sat0, 0);
    chk("rst_busy", busy0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
    chk("model_c00", coef(0, 0), 1448);
    chk("model_c10", coef(1, 0), 2009);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", s_ready0, 1);
    @(posedge clk); #1;

    // constant input: only DC survives
    frm = '{10, 10, 10, 10, 10, 10, 10, 10};
    send_frame(); wait_done();
    chk("const_z0", rec0[0], 28);
    chk("const_z1", rec0[1], 0);
    chk("const_z4", rec0[4], 0);
    chk("const_z7", rec0[7], 0);
    chk("const_last7", rlast0[7], 1);
    chk("const_last0", rlast0[0], 0);
    chk("const_sat0", rsat0[0], 0);

    // impulse: rounding versus truncation
    frm = '{64, 0, 0, 0, 0, 0, 0, 0};
    send_frame(); wait_done();
    chk("imp_rnd_z0", rec0[0], 23);
    chk("imp_rnd_z1", rec0[1], 31);
    chk("imp_rnd_z2", rec0[2], 30);
    chk("imp_trunc_z0", rec1[0], 22);
    chk("imp_trunc_z2", rec1[2], 29);

    // full-scale positive and negative into an 8-bit output
    frm = '{127, 127, 127, 127, 127, 127, 127, 127};
    send_frame(); wait_done();
    chk("pos_w8_z0", rec2[0], 127);
    chk("pos_w8_sat", rsat2[0], 1);
    chk("pos_w12_z0", rec0[0], 359);
    frm = '{-128, -128, -128, -128, -128, -128, -128, -128};
    send_frame(); wait_done();
    chk("neg_w8_z0", rec2[0], -128);
    chk("neg_w8_sat", rsat2[0], 1);
    chk("neg_w12_z0", rec0[0], -362);
    chk("neg_w12_sat", rsat0[0], 0);

    // backpressure on k=3 with a stray ready pulse while nothing is valid
    frm = '{1, -2, 3, -4, 5, -6, 7, -8};
    send_frame();
    wait_idx(2);
    @(posedge clk); #1; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    wait_idx(3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = 8'sd55;
      if (i == 4) begin
        m_ready = 1'b1; s_valid = 1'b0;
      end else begin
        @(negedge clk);
        chk("stall_valid", m_valid0, 1);
        chk("stall_s_ready", s_ready0, 0);
      end
    end
    wait_done();
    chk("stall_k4_latency", last_lat[4], 9);

    // enable dropped for 4 cycles during COMPUTE of k=0 and k=2
    frm = '{100, -50, 25, 0, -75, 127, -128, 60};
    send_frame();
    repeat (2) @(posedge clk);
    #1; en = 1'b0;
    @(negedge clk);
    chk("en_low_s_ready", s_ready0, 0);
    chk("en_low_busy", busy0, 1);
    repeat (4) @(posedge clk);
    #1; en = 1'b1;
    wait_idx(1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1; en = 1'b0;
    repeat (4) @(posedge clk);
    #1; en = 1'b1;
    wait_done();
    chk("en_z0_latency", last_lat[0], 13);
    chk("en_z1_latency", last_lat[1], 9);
    chk("en_z2_latency", last_lat[2], 13);

    // reset after 5 samples discards the partial frame
    for (int i = 0; i < 5; i++) send_sample(99);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    frm = '{64, 0, 0, 0, 0, 0, 0, 0};
    send_frame(); wait_done();
    chk("after_rst_z0", rec0[0], 23);
    chk("after_rst_z1", rec0[1], 31);

    // reset in the middle of the output phase
    frm = '{-7, 33, 12, -90, 45, 2, -1, 80};
    send_frame();
    wait_idx(2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    frm = '{10, 10, 10, 10, 10, 10, 10, 10};
    send_frame(); wait_done();
    chk("mid_out_rst_z0", rec0[0], 28);
    chk("mid_out_rst_z3", rec0[3], 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
